// File: rtl/multicycle_control_if.sv
// Control bundle between the multicycle control FSM and the shared datapath.
// The master side is the control unit; the slave side is the datapath/memory.
interface multicycle_control_if;
    logic [6:0] opcode;
    logic [2:0] funct3;
    logic       funct7_5;
    logic       alu_bcond;
    logic       mem_ready;

    logic       pc_write;
    logic       pc_source;
    logic       i_or_d;
    logic       mem_read;
    logic       mem_write;
    logic       ir_write;
    logic       reg_write;
    logic       wb_src;
    logic       alu_src_a;
    logic [1:0] alu_src_b;
    logic [3:0] alu_op;
    logic       is_halted;
    logic [2:0] state;

    modport master (
        input  opcode, funct3, funct7_5, alu_bcond, mem_ready,
        output pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_write, wb_src, alu_src_a, alu_src_b, alu_op, is_halted, state
    );

    modport slave (
        output opcode, funct3, funct7_5, alu_bcond, mem_ready,
        input  pc_write, pc_source, i_or_d, mem_read, mem_write, ir_write,
               reg_write, wb_src, alu_src_a, alu_src_b, alu_op, is_halted, state
    );
endinterface

// File: rtl/multicycle_control.sv
// Multicycle RV32I control FSM: decodes the latched IR fields and current
// state into ALU selects and datapath/memory enables, with a sticky halt.
module multicycle_control (
    input  logic                 clk,
    input  logic                 reset,
    multicycle_control_if.master bus
);
    typedef enum logic [2:0] {
        S_IF    = 3'd0,
        S_ID    = 3'd1,
        S_EX    = 3'd2,
        S_MEM   = 3'd3,
        S_WB    = 3'd4,
        S_BR_NT = 3'd5,
        S_HALT  = 3'd6
    } state_e;

    localparam logic [6:0] OPC_R      = 7'b0110011;
    localparam logic [6:0] OPC_I      = 7'b0010011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_ECALL  = 7'b1110011;

    localparam logic [3:0] OP_ADD = 4'd0;
    localparam logic [3:0] OP_SUB = 4'd1;
    localparam logic [3:0] OP_SLL = 4'd2;
    localparam logic [3:0] OP_XOR = 4'd3;
    localparam logic [3:0] OP_SRL = 4'd4;
    localparam logic [3:0] OP_OR  = 4'd5;
    localparam logic [3:0] OP_AND = 4'd6;
    localparam logic [3:0] OP_BEQ = 4'd7;
    localparam logic [3:0] OP_BNE = 4'd8;
    localparam logic [3:0] OP_BLT = 4'd9;
    localparam logic [3:0] OP_BGE = 4'd10;

    state_e     state_q, state_d;
    logic       halted_q, halted_d;
    logic       is_r, is_i, is_load, is_store, is_branch, is_jal, is_jalr, known;
    logic [3:0] arith_op, branch_op;
    logic       branch_ok;

    assign is_r      = (bus.opcode == OPC_R);
    assign is_i      = (bus.opcode == OPC_I);
    assign is_load   = (bus.opcode == OPC_LOAD);
    assign is_store  = (bus.opcode == OPC_STORE);
    assign is_branch = (bus.opcode == OPC_BRANCH);
    assign is_jal    = (bus.opcode == OPC_JAL);
    assign is_jalr   = (bus.opcode == OPC_JALR);
    assign known     = is_r | is_i | is_load | is_store | is_branch | is_jal | is_jalr;

    always_comb begin
        case (bus.funct3)
            3'b000:  arith_op = (is_r && bus.funct7_5) ? OP_SUB : OP_ADD;
            3'b001:  arith_op = OP_SLL;
            3'b100:  arith_op = OP_XOR;
            3'b101:  arith_op = OP_SRL;
            3'b110:  arith_op = OP_OR;
            3'b111:  arith_op = OP_AND;
            default: arith_op = OP_ADD;
        endcase
    end

    always_comb begin
        branch_ok = 1'b1;
        case (bus.funct3)
            3'b000:  branch_op = OP_BEQ;
            3'b001:  branch_op = OP_BNE;
            3'b100:  branch_op = OP_BLT;
            3'b101:  branch_op = OP_BGE;
            default: begin
                branch_op = OP_ADD;
                branch_ok = 1'b0;
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!reset) begin
            state_q  <= S_IF;
            halted_q <= 1'b0;
        end else begin
            state_q  <= state_d;
            halted_q <= halted_d;
        end
    end

    // Outputs decode state plus same-cycle mem_ready/alu_bcond, so they stay
    // combinational; reset low masks every output for the whole cycle.
    always_comb begin
        state_d       = state_q;
        halted_d      = halted_q;
        bus.pc_write  = 1'b0;
        bus.pc_source = 1'b0;
        bus.i_or_d    = 1'b0;
        bus.mem_read  = 1'b0;
        bus.mem_write = 1'b0;
        bus.ir_write  = 1'b0;
        bus.reg_write = 1'b0;
        bus.wb_src    = 1'b0;
        bus.alu_src_a = 1'b0;
        bus.alu_src_b = 2'd0;
        bus.alu_op    = OP_ADD;
        case (state_q)
            S_IF: begin
                bus.mem_read = 1'b1;
                bus.ir_write = bus.mem_ready;
                if (bus.mem_ready) state_d = S_ID;
            end
            S_ID: begin
                bus.alu_src_b = is_branch ? 2'd2 : 2'd1;
                if (bus.opcode == OPC_ECALL) begin
                    state_d  = S_HALT;
                    halted_d = 1'b1;
                end else if (!known) begin
                    state_d = S_BR_NT;
                end else begin
                    state_d = S_EX;
                end
            end
            S_EX: begin
                if (is_r || is_i) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = is_r ? 2'd0 : 2'd2;
                    bus.alu_op    = arith_op;
                    state_d       = S_WB;
                end else if (is_load || is_store) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_src_b = 2'd2;
                    state_d       = S_MEM;
                end else if (is_branch) begin
                    bus.alu_src_a = 1'b1;
                    bus.alu_op    = branch_op;
                    if (branch_ok && bus.alu_bcond) begin
                        bus.pc_write  = 1'b1;
                        bus.pc_source = 1'b1;
                        state_d       = S_IF;
                    end else begin
                        state_d = S_BR_NT;
                    end
                end else if (is_jal || is_jalr) begin
                    bus.alu_src_a = is_jalr;
                    bus.alu_src_b = 2'd2;
                    bus.pc_write  = 1'b1;
                    bus.reg_write = 1'b1;
                    state_d       = S_IF;
                end else begin
                    state_d = S_BR_NT;
                end
            end
            S_MEM: begin
                bus.i_or_d    = 1'b1;
                bus.mem_read  = is_load;
                bus.mem_write = is_store;
                bus.alu_src_b = is_store ? 2'd1 : 2'd0;
                if (bus.mem_ready) begin
                    if (is_load) begin
                        state_d = S_WB;
                    end else begin
                        bus.pc_write = 1'b1;
                        state_d      = S_IF;
                    end
                end
            end
            S_WB: begin
                bus.reg_write = 1'b1;
                bus.wb_src    = is_load;
                bus.alu_src_b = 2'd1;
                bus.pc_write  = 1'b1;
                state_d       = S_IF;
            end
            S_BR_NT: begin
                bus.alu_src_b = 2'd1;
                bus.pc_write  = 1'b1;
                state_d       = S_IF;
            end
            S_HALT: begin
                state_d = S_HALT;
            end
            default: begin
                state_d = S_IF;
            end
        endcase
        bus.is_halted = halted_q;
        bus.state     = state_q;
        if (!reset) begin
            bus.pc_write  = 1'b0;
            bus.pc_source = 1'b0;
            bus.i_or_d    = 1'b0;
            bus.mem_read  = 1'b0;
            bus.mem_write = 1'b0;
            bus.ir_write  = 1'b0;
            bus.reg_write = 1'b0;
            bus.wb_src    = 1'b0;
            bus.alu_src_a = 1'b0;
            bus.alu_src_b = 2'd0;
            bus.alu_op    = 4'd0;
            bus.is_halted = 1'b0;
            bus.state     = 3'd0;
        end
    end
endmodule
